// File: rtl/snax_stream_shell_ctrl.sv
// snax_stream_shell_ctrl: control shell between the streamer/CSR manager and a
// multi-core SNAX accelerator. It gates the input/output stream channels with a
// per-job enable mask, forwards the core configuration over valid/ready, counts
// output beats to detect job completion, and exposes busy/perf/stall RO CSRs.
// Optional macro SNAX_SHELL_STALL_CNT_EN enables the output stall counter
// (RO word2); without it RO word2 reads 0 and no counter exists.
module snax_stream_shell_ctrl #(
  parameter int unsigned NumInCh      = 14,
  parameter int unsigned NumOutCh     = 4,
  parameter int unsigned DataWidth    = 512,
  parameter int unsigned RegRWCount   = 6,
  parameter int unsigned RegROCount   = 3,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned CntWidth     = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [RegRWCount*RegDataWidth-1:0]       csr_reg_set_i,
  input  logic                                     csr_reg_set_valid_i,
  output logic                                     csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0]       csr_reg_ro_set_o,
  input  logic [NumInCh*DataWidth-1:0]             s_in_data_i,
  input  logic [NumInCh-1:0]                       s_in_valid_i,
  output logic [NumInCh-1:0]                       s_in_ready_o,
  output logic [NumInCh*DataWidth-1:0]             core_in_data_o,
  output logic [NumInCh-1:0]                       core_in_valid_o,
  input  logic [NumInCh-1:0]                       core_in_ready_i,
  input  logic [NumOutCh*DataWidth-1:0]            core_out_data_i,
  input  logic [NumOutCh-1:0]                      core_out_valid_i,
  output logic [NumOutCh-1:0]                      core_out_ready_o,
  output logic [NumOutCh*DataWidth-1:0]            s_out_data_o,
  output logic [NumOutCh-1:0]                      s_out_valid_o,
  input  logic [NumOutCh-1:0]                      s_out_ready_i,
  output logic [(RegRWCount-2)*RegDataWidth-1:0]   core_cfg_o,
  output logic                                     core_cfg_valid_o,
  input  logic                                     core_cfg_ready_i
);

  localparam int unsigned CfgBits = (RegRWCount - 2) * RegDataWidth;

  typedef enum logic [1:0] {StIdle, StCfg, StRun} state_e;

  state_e                             state_q, state_d;
  logic [NumInCh-1:0]                 in_mask_q, in_mask_d;
  logic [NumOutCh-1:0]                out_mask_q, out_mask_d;
  logic [CntWidth-1:0]                target_q, target_d;
  logic [CfgBits-1:0]                 cfg_q, cfg_d;
  logic [CntWidth-1:0]                perf_q, perf_d;
  logic [NumOutCh-1:0][CntWidth-1:0]  beat_cnt_q, beat_cnt_d;
  logic [NumOutCh-1:0][CntWidth-1:0]  cnt_next;
  logic [NumOutCh-1:0]                ch_open;
  logic                               run;
  logic                               start;
  logic                               done_all;
  logic                               unused_csr;

  // Only the mask/target/config fields of the CSR words are consumed.
  assign unused_csr = ^csr_reg_set_i;
  assign run        = (state_q == StRun);
  assign core_cfg_o = cfg_q;

  // Channel gating and beat bookkeeping; data is always passed straight through.
  always_comb begin
    core_in_data_o   = s_in_data_i;
    s_out_data_o     = core_out_data_i;
    core_in_valid_o  = run ? (in_mask_q & s_in_valid_i) : '0;
    s_in_ready_o     = run ? (in_mask_q & core_in_ready_i) : '0;
    s_out_valid_o    = '0;
    core_out_ready_o = '0;
    ch_open          = '0;
    cnt_next         = beat_cnt_q;
    done_all         = 1'b1;
    for (int unsigned j = 0; j < NumOutCh; j++) begin
      ch_open[j] = run && out_mask_q[j] && (beat_cnt_q[j] < target_q);
      s_out_valid_o[j] = ch_open[j] && core_out_valid_i[j];
      // Disabled channels sink the core's output so it never stalls on them.
      core_out_ready_o[j] = ch_open[j] ? s_out_ready_i[j] : (run && !out_mask_q[j]);
      cnt_next[j] = beat_cnt_q[j]
                  + CntWidth'(ch_open[j] && core_out_valid_i[j] && s_out_ready_i[j]);
      // Completion looks at the post-beat count so the last beat's cycle ends the job.
      if (out_mask_q[j] && (cnt_next[j] != target_q)) done_all = 1'b0;
    end
  end

  // Job FSM: accept CSR set, hand config to the core, run until all beats are out.
  always_comb begin
    state_d             = state_q;
    in_mask_d           = in_mask_q;
    out_mask_d          = out_mask_q;
    target_d            = target_q;
    cfg_d               = cfg_q;
    csr_reg_set_ready_o = 1'b0;
    core_cfg_valid_o    = 1'b0;
    start               = 1'b0;
    unique case (state_q)
      StIdle: begin
        csr_reg_set_ready_o = 1'b1;
        if (csr_reg_set_valid_i) begin
          start      = 1'b1;
          in_mask_d  = csr_reg_set_i[NumInCh-1:0];
          out_mask_d = csr_reg_set_i[NumInCh +: NumOutCh];
          target_d   = csr_reg_set_i[RegDataWidth +: CntWidth];
          cfg_d      = csr_reg_set_i[2*RegDataWidth +: CfgBits];
          state_d    = StCfg;
        end
      end
      StCfg: begin
        core_cfg_valid_o = 1'b1;
        if (core_cfg_ready_i) begin
          if ((target_q == '0) || ((in_mask_q == '0) && (out_mask_q == '0))) state_d = StIdle;
          else state_d = StRun;
        end
      end
      StRun: begin
        if (done_all) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    beat_cnt_d = start ? '0 : cnt_next;
    if (start) perf_d = '0;
    else if ((state_q != StIdle) && (perf_q != '1)) perf_d = perf_q + 1'b1;
    else perf_d = perf_q;
  end

  // Job state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      in_mask_q  <= '0;
      out_mask_q <= '0;
      target_q   <= '0;
      cfg_q      <= '0;
      perf_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_mask_q  <= in_mask_d;
      out_mask_q <= out_mask_d;
      target_q   <= target_d;
      cfg_q      <= cfg_d;
      perf_q     <= perf_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef SNAX_SHELL_STALL_CNT_EN
  logic [CntWidth-1:0] stall_q, stall_d;

  // Count RUN cycles where an unfinished enabled channel is blocked by the streamer.
  always_comb begin
    if (start) stall_d = '0;
    else if (|(ch_open & core_out_valid_i & ~s_out_ready_i) && (stall_q != '1))
      stall_d = stall_q + 1'b1;
    else stall_d = stall_q;
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif

  // Read-only CSR words: busy, perf, stall.
  always_comb begin
    csr_reg_ro_set_o    = '0;
    csr_reg_ro_set_o[0] = (state_q != StIdle);
    csr_reg_ro_set_o[RegDataWidth +: CntWidth] = perf_q;
`ifdef SNAX_SHELL_STALL_CNT_EN
    csr_reg_ro_set_o[2*RegDataWidth +: CntWidth] = stall_q;
`endif
  end

endmodule

// File: tb/tb_snax_stream_shell_ctrl.sv
// Directed bench for snax_stream_shell_ctrl with a job-level reference model.
module tb_snax_stream_shell_ctrl;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int RO = 3;
  localparam int RDW = 32;
  localparam int CW = 16;
  localparam int PMAX = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [RW*RDW-1:0]     csr_set;
  logic                  csr_valid;
  logic                  csr_ready;
  logic [RO*RDW-1:0]     ro;
  logic [NI*DW-1:0]      s_in_data;
  logic [NI-1:0]         s_in_valid, s_in_ready;
  logic [NI*DW-1:0]      core_in_data;
  logic [NI-1:0]         core_in_valid, core_in_ready;
  logic [NO*DW-1:0]      core_out_data;
  logic [NO-1:0]         core_out_valid, core_out_ready;
  logic [NO*DW-1:0]      s_out_data;
  logic [NO-1:0]         s_out_valid, s_out_ready;
  logic [(RW-2)*RDW-1:0] cfg_o;
  logic                  cfg_valid, cfg_ready;

  int total = 0;
  int bad = 0;

  snax_stream_shell_ctrl #(
    .NumInCh(NI), .NumOutCh(NO), .DataWidth(DW), .RegRWCount(RW),
    .RegROCount(RO), .RegDataWidth(RDW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_valid),
    .csr_reg_set_ready_o(csr_ready), .csr_reg_ro_set_o(ro),
    .s_in_data_i(s_in_data), .s_in_valid_i(s_in_valid), .s_in_ready_o(s_in_ready),
    .core_in_data_o(core_in_data), .core_in_valid_o(core_in_valid),
    .core_in_ready_i(core_in_ready),
    .core_out_data_i(core_out_data), .core_out_valid_i(core_out_valid),
    .core_out_ready_o(core_out_ready),
    .s_out_data_o(s_out_data), .s_out_valid_o(s_out_valid), .s_out_ready_i(s_out_ready),
    .core_cfg_o(cfg_o), .core_cfg_valid_o(cfg_valid), .core_cfg_ready_i(cfg_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for a job, 1 = offering config, 2 = streaming.
  int          m_phase;
  bit          model_ok = 1'b0;
  logic [NI-1:0] m_in;
  logic [NO-1:0] m_out;
  int          m_target;
  logic [(RW-2)*RDW-1:0] m_cfg;
  int          m_perf, m_stall;
  int          m_beats[NO];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = 0; m_in = '0; m_out = '0; m_target = 0; m_cfg = '0;
        m_perf = 0; m_stall = 0;
        for (int j = 0; j < NO; j++) m_beats[j] = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (m_phase == 0) begin
          if (csr_valid) begin
            m_in = csr_set[0 +: NI];
            m_out = csr_set[NI +: NO];
            m_target = int'(csr_set[RDW +: CW]);
            m_cfg = csr_set[2*RDW +: (RW-2)*RDW];
            m_perf = 0; m_stall = 0;
            for (int j = 0; j < NO; j++) m_beats[j] = 0;
            m_phase = 1;
          end
        end else begin
          bit stalled, all_done;
          if (m_perf < PMAX) m_perf++;
          if (m_phase == 1) begin
            if (cfg_ready)
              m_phase = (m_target == 0 || (m_in == 0 && m_out == 0)) ? 0 : 2;
          end else begin
            stalled = 1'b0;
            all_done = 1'b1;
            for (int j = 0; j < NO; j++) begin
              if (m_out[j] && m_beats[j] < m_target) begin
                if (core_out_valid[j] && s_out_ready[j]) m_beats[j]++;
                else if (core_out_valid[j]) stalled = 1'b1;
              end
              if (m_out[j] && m_beats[j] != m_target) all_done = 1'b0;
            end
`ifdef SNAX_SHELL_STALL_CNT_EN
            if (stalled && m_stall < PMAX) m_stall++;
`endif
            if (all_done) m_phase = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        logic [NI-1:0] e_civ, e_sir;
        logic [NO-1:0] e_sov, e_cor;
        bit run, open;
        run = (m_phase == 2);
        for (int i = 0; i < NI; i++) begin
          e_civ[i] = run && m_in[i] && s_in_valid[i];
          e_sir[i] = run && m_in[i] && core_in_ready[i];
        end
        for (int j = 0; j < NO; j++) begin
          open = run && m_out[j] && (m_beats[j] < m_target);
          e_sov[j] = open && core_out_valid[j];
          e_cor[j] = open ? s_out_ready[j] : (run && !m_out[j]);
        end
        chk("csr_ready", csr_ready, m_phase == 0);
        chk("cfg_valid", cfg_valid, m_phase == 1);
        chk("ro_busy", ro[0 +: RDW], m_phase != 0);
        chk("ro_perf", ro[RDW +: RDW], m_perf);
        chk("ro_stall", ro[2*RDW +: RDW], m_stall);
        chk("cfg_o", cfg_o, m_cfg);
        chk("core_in_valid", core_in_valid, e_civ);
        chk("s_in_ready", s_in_ready, e_sir);
        chk("s_out_valid", s_out_valid, e_sov);
        chk("core_out_ready", core_out_ready, e_cor);
        chk("in_data", core_in_data, s_in_data);
        chk("out_data", s_out_data, core_out_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s_in_data = $urandom;
    core_out_data = NO*DW'($urandom);
  endtask

  // Present a job on the CSR port for one handshake edge.
  task automatic start_job(input logic [NI-1:0] im, input logic [NO-1:0] om,
                           input logic [CW-1:0] tgt, input logic [31:0] c0,
                           input logic [31:0] c1);
    csr_set = '0;
    csr_set[0 +: NI] = im;
    csr_set[NI +: NO] = om;
    csr_set[8 +: 24] = 24'h5A5A5A;
    csr_set[RDW +: RDW] = {16'hDEAD, tgt};
    csr_set[2*RDW +: RDW] = c0;
    csr_set[3*RDW +: RDW] = c1;
    csr_valid = 1'b1;
    tick();
    csr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; csr_set = '0; csr_valid = 1'b0; cfg_ready = 1'b1;
    s_in_data = '0; s_in_valid = '1; core_in_ready = '1;
    core_out_data = '0; core_out_valid = '0; s_out_ready = '1;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", csr_ready, 1'b1);
    chk("rst_busy", ro[0 +: RDW], 0);
    chk("rst_perf", ro[RDW +: RDW], 0);
    chk("rst_cfg", cfg_o, 0);
    chk("rst_civ", core_in_valid, 0);
    chk("rst_cor", core_out_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic job: one idle RUN cycle then four beats on channel 0.
    start_job(4'h3, 3'b001, 16'd4, 32'hA5A5_0001, 32'h1234_5678);
    @(negedge clk);
    chk("t1_busy_rise", ro[0 +: RDW], 1);
    chk("t1_cfg_valid", cfg_valid, 1'b1);
    tick(); tick();
    core_out_valid = 3'b001;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t1_busy_before_last", ro[0 +: RDW], 1);
    tick();
    core_out_valid = '0;
    @(negedge clk);
    chk("t1_busy_done", ro[0 +: RDW], 0);
    chk("t1_ready", csr_ready, 1'b1);
    chk("t1_perf", ro[RDW +: RDW], 6);
    chk("t1_cfg_o", cfg_o, 64'h1234_5678_A5A5_0001);

    // Masking, plus a CSR set attempt during RUN that must be ignored.
    s_in_valid = 4'b0011;
    core_out_valid = 3'b100;
    start_job(4'h1, 3'b001, 16'd2, 32'h1, 32'h2);
    tick();
    @(negedge clk);
    chk("t2_in1_ready", s_in_ready[1], 1'b0);
    chk("t2_in1_valid", core_in_valid[1], 1'b0);
    chk("t2_in0_valid", core_in_valid[0], 1'b1);
    chk("t2_out2_sink", core_out_ready[2], 1'b1);
    chk("t2_out2_valid", s_out_valid[2], 1'b0);
    csr_valid = 1'b1;
    core_out_valid = 3'b101;
    tick();
    csr_valid = 1'b0;
    tick();
    core_out_valid = '0;
    @(negedge clk);
    chk("t2_done", ro[0 +: RDW], 0);
    chk("t2_perf", ro[RDW +: RDW], 3);
    s_in_valid = '1;

    // Overrun: channel 1 offers beats continuously, channel 0 lags.
    core_out_valid = 3'b010;
    start_job(4'h0, 3'b011, 16'd2, 32'h3, 32'h4);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t3_gate_ready", core_out_ready[1], 1'b0);
    chk("t3_gate_valid", s_out_valid[1], 1'b0);
    chk("t3_busy", ro[0 +: RDW], 1);
    core_out_valid = 3'b011;
    tick(); tick();
    core_out_valid = '0;
    @(negedge clk);
    chk("t3_done", ro[0 +: RDW], 0);
    chk("t3_perf", ro[RDW +: RDW], 5);

    // Zero target: config handshake then straight back to idle.
    start_job(4'h1, 3'b001, 16'd0, 32'h5, 32'h6);
    @(negedge clk);
    chk("t4_cfg_valid", cfg_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("t4_idle", ro[0 +: RDW], 0);
    chk("t4_perf", ro[RDW +: RDW], 1);

    // Back-pressure: config stalled 3 cycles, streamer stalled 5 cycles.
    cfg_ready = 1'b0;
    core_out_valid = 3'b101;
    start_job(4'h0, 3'b101, 16'd4, 32'h7, 32'h8);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t5_cfg_held", cfg_valid, 1'b1);
    cfg_ready = 1'b1;
    tick(); tick(); tick();
    s_out_ready = '0;
    repeat (5) tick();
    s_out_ready = '1;
    tick(); tick();
    core_out_valid = '0;
    @(negedge clk);
    chk("t5_done", ro[0 +: RDW], 0);
    chk("t5_perf", ro[RDW +: RDW], 13);
`ifdef SNAX_SHELL_STALL_CNT_EN
    chk("t5_stall", ro[2*RDW +: RDW], 5);
`else
    chk("t5_stall", ro[2*RDW +: RDW], 0);
`endif

    // Reset mid-RUN after 2 of 4 beats, then a fresh job.
    core_out_valid = 3'b001;
    start_job(4'h3, 3'b001, 16'd4, 32'h9, 32'hA);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy", ro[0 +: RDW], 0);
    chk("t6_ready", csr_ready, 1'b1);
    chk("t6_perf", ro[RDW +: RDW], 0);
    chk("t6_stall", ro[2*RDW +: RDW], 0);
    chk("t6_cfg", cfg_o, 0);
    start_job(4'h3, 3'b001, 16'd2, 32'hB, 32'hC);
    tick(); tick();
    @(negedge clk);
    chk("t6_fresh_mid", ro[0 +: RDW], 1);
    tick();
    core_out_valid = '0;
    @(negedge clk);
    chk("t6_fresh_done", ro[0 +: RDW], 0);
    chk("t6_fresh_perf", ro[RDW +: RDW], 3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snax_stream_shell_ctrl.md
Name: snax_stream_shell_ctrl

Overview:
Parametrised successor of the SimbaCore shell wrapper; a generic control shell between the streamer/CSR manager and a multi-core SNAX accelerator.
- Gates a configurable number of input and output stream channels with a per-job channel-enable mask.
- Forwards core configuration over a valid/ready handshake.
- Counts output beats to detect job completion autonomously.
- Exposes busy, performance and stall counters as read-only CSRs.
- Unused channels are masked off, so one shell serves every core mode (OS, IS, SU, switch).

Parameters:
- NumInCh, 14, number of streamer-to-accelerator channels (NumInCh+NumOutCh <= 32)
- NumOutCh, 4, number of accelerator-to-streamer channels
- DataWidth, 512, per-channel data width; channels packed flat, channel i at [i*DataWidth +: DataWidth]
- RegRWCount, 6, RW CSR count (>= 3)
- RegROCount, 3, RO CSR count (>= 3)
- RegDataWidth, 32, CSR word width
- CntWidth, 32, beat/perf counter width (<= RegDataWidth)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- csr_reg_set_i  in  RegRWCount*RegDataWidth  RW CSR words; the valid handshake is the job start
- csr_reg_set_valid_i  in  1  CSR set valid
- csr_reg_set_ready_o  out  1  CSR set ready
- csr_reg_ro_set_o  out  RegROCount*RegDataWidth  RO CSR words
- s_in_data_i  in  NumInCh*DataWidth  streamer input data
- s_in_valid_i  in  NumInCh  per-channel valid
- s_in_ready_o  out  NumInCh  per-channel ready
- core_in_data_o  out  NumInCh*DataWidth  data to core
- core_in_valid_o  out  NumInCh  valid to core
- core_in_ready_i  in  NumInCh  ready from core
- core_out_data_i  in  NumOutCh*DataWidth  core output data
- core_out_valid_i  in  NumOutCh  core output valid
- core_out_ready_o  out  NumOutCh  ready to core
- s_out_data_o  out  NumOutCh*DataWidth  data to streamer
- s_out_valid_o  out  NumOutCh  valid to streamer
- s_out_ready_i  in  NumOutCh  ready from streamer
- core_cfg_o  out  (RegRWCount-2)*RegDataWidth  config words 2..RegRWCount-1, registered
- core_cfg_valid_o  out  1  config valid
- core_cfg_ready_i  in  1  config ready

Behaviour:
CSR map:
- word0[NumInCh-1:0] = input enable mask
- word0[NumInCh+NumOutCh-1:NumInCh] = output enable mask
- word1 = expected beats per enabled output channel (low CntWidth bits)
- words 2..RegRWCount-1 = core config

FSM states are IDLE, CFG, RUN.
- IDLE: csr_reg_set_ready_o=1. On valid&ready, latch masks, beat target and config; clear perf/stall counters and all beat counters; go to CFG.
- CFG: core_cfg_valid_o=1, held until core_cfg_ready_i. On that handshake, go to RUN; if target==0 or both masks are 0, go to IDLE instead.
- RUN: stays until every enabled output channel's beat counter equals the target, then goes to IDLE on the next edge.
- csr_reg_set_ready_o=0 in CFG and RUN; CSR valid is ignored there, with no queuing.

Datapath (combinational, zero latency, data always passed through):
- Enabled input channel in RUN: core_in_valid_o=s_in_valid_i, s_in_ready_o=core_in_ready_i.
- Otherwise: both 0.
- Enabled output channel in RUN with count < target: s_out_valid_o=core_out_valid_i, core_out_ready_o=s_out_ready_i. Count increments on s_out_valid_o&s_out_ready_i.
- Enabled output channel at count==target: valid/ready gated to 0. Extra beats are held back in the core, never dropped.
- Disabled output channel in RUN: core_out_ready_o=1 (sink/discard), s_out_valid_o=0.
- Outside RUN: all output valid/ready = 0.

Read-only registers:
- RO word0 = {0, busy}; busy=1 in CFG/RUN.
- RO word1 = perf counter: counts cycles in CFG+RUN, saturates at all-ones, holds after the job until the next start.
- RO word2 = stall counter (see Optional Feature).

Timing and boundaries:
- The last beat's handshake cycle is in RUN; busy=0 and ready=1 on the next cycle.
- Channels completing on the same cycle are each counted once.
- Reset values: state IDLE; all counters, masks and core_cfg_o = 0; all valid/ready outputs 0 except csr_reg_set_ready_o=1.
- Reset mid-job: returns to IDLE on the next edge; in-flight beats are abandoned.

Optional Feature:
SNAX_SHELL_STALL_CNT_EN
- Defined: RO word2 counts RUN cycles where any enabled, unfinished output channel has core_out_valid_i=1 and s_out_ready_i=0; saturating; cleared on start.
- Undefined: RO word2 tied to 0 and no counter logic is instantiated.

Test Plan:
- Basic job: word0 = in mask 0x3, out mask bit0, target 4; core_cfg_ready_i=1, 4 output beats with ready=1 -> busy rises 1 cycle after the start handshake; returns to IDLE 1 cycle after beat 4; perf = 6 (1 CFG + 5 RUN).
- Masking: in mask 0x1; channel 1 valid=1 -> s_in_ready_o[1] and core_in_valid_o[1] stay 0. Disabled output channel 2 valid=1 -> core_out_ready_o[2]=1, s_out_valid_o[2]=0.
- Overrun: target 2, core presents 3 beats -> third beat not accepted (core_out_ready_o=0); FSM reaches IDLE after beat 2.
- Zero target: word1=0 -> CFG handshake, then IDLE; no RUN cycle; perf = 1.
- Back-pressure: core_cfg_ready_i low for 3 cycles, then s_out_ready_i low for 5 cycles mid-RUN -> perf includes all waits; stall = 5 with the macro, 0 without.
- Reset mid-RUN after 2 of 4 beats -> next cycle IDLE, busy=0, counters 0, csr_reg_set_ready_o=1; a new start behaves as a fresh job.
